// File: rtl/sd_seq_pkg.sv
// sd_seq_pkg: shared encodings and frame formatting
// for the SD single-block transfer sequencer.
package sd_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CMD       = 3'd1,
        ST_DATA      = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_DONE      = 3'd4,
        ST_ERROR     = 3'd5
    } state_t;

    localparam logic [2:0] FLAG_CMD_ACK   = 3'b100;
    localparam logic [2:0] FLAG_DATA_DONE = 3'b101;
    localparam logic [2:0] FLAG_XFER_DONE = 3'b110;
    localparam logic [2:0] FLAG_CARD_ERR  = 3'b111;

    localparam logic [5:0] CMD17 = 6'd17;
    localparam logic [5:0] CMD24 = 6'd24;

    localparam logic [47:0] IDLE_FRAME  = 48'hFFFF_FFFF_FFFF;
    localparam logic [7:0]  DATA_TOKEN  = 8'hFE;
    localparam logic [7:0]  CMD_TRAILER = 8'h01;

    // Command frame: start bits, index, address, trailer
    function automatic logic [47:0] cmd_frame(
        input logic        i_op,
        input logic [31:0] i_addr
    );
        logic [5:0] v_idx;
        v_idx = i_op ? CMD24 : CMD17;
        return {2'b01, v_idx, i_addr, CMD_TRAILER};
    endfunction

    // Data frame: start token, payload word, pad byte
    function automatic logic [47:0] data_frame(
        input logic [31:0] i_wdata
    );
        return {DATA_TOKEN, i_wdata, 8'h00};
    endfunction

endpackage

// File: rtl/sd_block_sequencer.sv
// sd_block_sequencer: single-block CMD17/CMD24 sequencer.
// Optional wait-state timeout enabled by macro SD_SEQ_TIMEOUT_EN.
module sd_block_sequencer
    import sd_seq_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'hFFFF,
    parameter logic [8:0]  STATUS_ACTIVE  = 9'b110100111
) (
    input  logic        master_clk_i,
    input  logic        master_rst_i,
    input  logic        seq_start_i,
    input  logic        seq_op_i,
    input  logic [31:0] seq_block_addr_i,
    input  logic [31:0] seq_wdata_i,
    input  logic [2:0]  spi_flagreg_i,
    output logic [47:0] spi_data_o,
    output logic [8:0]  spi_statusreg_o,
    output logic        seq_busy_o,
    output logic        seq_done_o,
    output logic        seq_error_o
);

    state_t      r_state;
    state_t      w_next;
    logic        r_op;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        w_timeout;
    logic        w_abort;

`ifdef SD_SEQ_TIMEOUT_EN
    logic [15:0] r_cnt;

    assign w_timeout = (r_cnt == TIMEOUT_CYCLES - 16'd1);

    // Per-state wait counter, restarted on every state entry
    always_ff @(posedge master_clk_i) begin
        if (master_rst_i) begin
            r_cnt <= 16'd0;
        end else if (w_next != r_state) begin
            r_cnt <= 16'd0;
        end else if (r_state == ST_CMD || r_state == ST_DATA ||
                     r_state == ST_WAIT_DONE) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end
`else
    // No counter: waiting states never expire
    assign w_timeout = 1'b0 && (TIMEOUT_CYCLES != 16'd0);
`endif

    assign w_abort = (spi_flagreg_i == FLAG_CARD_ERR) || w_timeout;

    // Next-state decode; card error and timeout win over progress flags
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (seq_start_i) w_next = ST_CMD;
            end
            ST_CMD: begin
                if (w_abort)
                    w_next = ST_ERROR;
                else if (spi_flagreg_i == FLAG_CMD_ACK)
                    w_next = r_op ? ST_DATA : ST_WAIT_DONE;
            end
            ST_DATA: begin
                if (w_abort)
                    w_next = ST_ERROR;
                else if (spi_flagreg_i == FLAG_DATA_DONE)
                    w_next = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (w_abort)
                    w_next = ST_ERROR;
                else if (spi_flagreg_i == FLAG_XFER_DONE)
                    w_next = ST_DONE;
            end
            ST_DONE:  w_next = ST_IDLE;
            ST_ERROR: w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // State, request latch and Moore outputs registered on the same edge
    always_ff @(posedge master_clk_i) begin
        if (master_rst_i) begin
            r_state         <= ST_IDLE;
            r_op            <= 1'b0;
            r_addr          <= 32'd0;
            r_wdata         <= 32'd0;
            spi_data_o      <= IDLE_FRAME;
            spi_statusreg_o <= 9'd0;
            seq_busy_o      <= 1'b0;
            seq_done_o      <= 1'b0;
            seq_error_o     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && seq_start_i) begin
                r_op    <= seq_op_i;
                r_addr  <= seq_block_addr_i;
                r_wdata <= seq_wdata_i;
            end
            seq_done_o  <= 1'b0;
            seq_error_o <= 1'b0;
            unique case (w_next)
                ST_CMD: begin
                    if (r_state == ST_IDLE)
                        spi_data_o <= cmd_frame(seq_op_i, seq_block_addr_i);
                    else
                        spi_data_o <= cmd_frame(r_op, r_addr);
                    spi_statusreg_o <= STATUS_ACTIVE;
                    seq_busy_o      <= 1'b1;
                end
                ST_DATA: begin
                    spi_data_o      <= data_frame(r_wdata);
                    spi_statusreg_o <= STATUS_ACTIVE;
                    seq_busy_o      <= 1'b1;
                end
                ST_WAIT_DONE: begin
                    spi_data_o      <= IDLE_FRAME;
                    spi_statusreg_o <= STATUS_ACTIVE;
                    seq_busy_o      <= 1'b1;
                end
                ST_DONE: begin
                    spi_data_o      <= IDLE_FRAME;
                    spi_statusreg_o <= 9'd0;
                    seq_busy_o      <= 1'b1;
                    seq_done_o      <= 1'b1;
                end
                ST_ERROR: begin
                    spi_data_o      <= IDLE_FRAME;
                    spi_statusreg_o <= 9'd0;
                    seq_busy_o      <= 1'b1;
                    seq_error_o     <= 1'b1;
                end
                default: begin
                    spi_data_o      <= IDLE_FRAME;
                    spi_statusreg_o <= 9'd0;
                    seq_busy_o      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_block_sequencer.sv
// tb_sd_block_sequencer: scoreboard bench for sd_block_sequencer.
// Timeout scenario follows macro SD_SEQ_TIMEOUT_EN.
module tb_sd_block_sequencer;

    localparam logic [47:0] IDLE_F = 48'hFFFF_FFFF_FFFF;
    localparam logic [8:0]  ACT    = 9'b110100111;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  flag;
    logic [47:0] spi_data;
    logic [8:0]  spi_status;
    logic        busy;
    logic        done;
    logic        err;

    typedef struct {
        logic [47:0] d;
        logic [8:0]  s;
        logic        b;
        logic        dn;
        logic        er;
        int          c;
        int          tag;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   tag = 0;
    int   checks = 0;
    int   failures = 0;
    int   t0;

    sd_block_sequencer #(
        .TIMEOUT_CYCLES(16'd8),
        .STATUS_ACTIVE (9'b110100111)
    ) dut (
        .master_clk_i    (clk),
        .master_rst_i    (rst),
        .seq_start_i     (start),
        .seq_op_i        (op),
        .seq_block_addr_i(addr),
        .seq_wdata_i     (wdata),
        .spi_flagreg_i   (flag),
        .spi_data_o      (spi_data),
        .spi_statusreg_o (spi_status),
        .seq_busy_o      (busy),
        .seq_done_o      (done),
        .seq_error_o     (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic ex(
        input logic [47:0] d,
        input logic [8:0]  s,
        input logic        b,
        input logic        dn,
        input logic        er,
        input int          c
    );
        exp_t e;
        e.d = d; e.s = s; e.b = b; e.dn = dn; e.er = er;
        e.c = c; e.tag = tag;
        q.push_back(e);
        tag++;
    endtask

    // Monitor: every change of the output bundle pops one expectation
    initial begin
        logic [59:0] prev;
        logic [59:0] cur;
        exp_t        e;
        prev = {48'd0, 9'd0, 1'b1, 1'b0, 1'b0};
        forever begin
            @(negedge clk);
            cur = {spi_data, spi_status, busy, done, err};
            if (cur !== prev) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_change cyc=%0d got data=%h st=%b busy=%b done=%b err=%b",
                             cyc, spi_data, spi_status, busy, done, err);
                end else begin
                    e = q.pop_front();
                    if (spi_data !== e.d || spi_status !== e.s ||
                        busy !== e.b || done !== e.dn || err !== e.er ||
                        (e.c >= 0 && e.c != cyc)) begin
                        failures++;
                        $display("FAIL rec%0d got data=%h st=%b busy=%b done=%b err=%b cyc=%0d want data=%h st=%b busy=%b done=%b err=%b cyc=%0d",
                                 e.tag, spi_data, spi_status, busy, done, err, cyc,
                                 e.d, e.s, e.b, e.dn, e.er, e.c);
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; op = 1'b0;
        addr = 32'd0; wdata = 32'd0; flag = 3'b000;
        ex(IDLE_F, 9'd0, 1'b0, 1'b0, 1'b0, -1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // write 0x2A00 / 0x86232200
        @(negedge clk);
        start = 1'b1; op = 1'b1;
        addr = 32'h0000_2A00; wdata = 32'h8623_2200;
        ex(48'h5800002A0001, ACT, 1'b1, 1'b0, 1'b0, cyc + 1);
        @(negedge clk);
        start = 1'b0; addr = 32'hFFFF_0000; wdata = 32'h0;
        flag = 3'b100;
        ex(48'hFE8623220000, ACT, 1'b1, 1'b0, 1'b0, cyc + 1);
        @(negedge clk);
        flag = 3'b101;
        ex(IDLE_F, ACT, 1'b1, 1'b0, 1'b0, cyc + 1);
        @(negedge clk);
        flag = 3'b110;
        ex(IDLE_F, 9'd0, 1'b1, 1'b1, 1'b0, cyc + 1);
        ex(IDLE_F, 9'd0, 1'b0, 1'b0, 1'b0, cyc + 2);
        @(negedge clk);
        flag = 3'b000;
        repeat (2) @(negedge clk);

        // read 0x10, with stray flags ignored
        start = 1'b1; op = 1'b0; addr = 32'h0000_0010; wdata = 32'h0;
        ex(48'h510000001001, ACT, 1'b1, 1'b0, 1'b0, cyc + 1);
        @(negedge clk);
        start = 1'b0; addr = 32'hFFFF_FFFF; flag = 3'b101;
        @(negedge clk);
        flag = 3'b110;
        @(negedge clk);
        flag = 3'b100;
        ex(IDLE_F, ACT, 1'b1, 1'b0, 1'b0, cyc + 1);
        @(negedge clk);
        flag = 3'b100;
        @(negedge clk);
        flag = 3'b110;
        ex(IDLE_F, 9'd0, 1'b1, 1'b1, 1'b0, cyc + 1);
        ex(IDLE_F, 9'd0, 1'b0, 1'b0, 1'b0, cyc + 2);
        // start raised during DONE, held into the following IDLE cycle
        @(negedge clk);
        flag = 3'b000; start = 1'b1; op = 1'b1;
        addr = 32'h1234_5678; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        ex(48'h581234567801, ACT, 1'b1, 1'b0, 1'b0, cyc + 1);
        @(negedge clk);
        start = 1'b0; flag = 3'b100;
        ex(48'hFEDEADBEEF00, ACT, 1'b1, 1'b0, 1'b0, cyc + 1);
        @(negedge clk);
        flag = 3'b000; start = 1'b1; op = 1'b0; addr = 32'h0;
        @(negedge clk);
        start = 1'b0; flag = 3'b111;
        ex(IDLE_F, 9'd0, 1'b1, 1'b0, 1'b1, cyc + 1);
        ex(IDLE_F, 9'd0, 1'b0, 1'b0, 1'b0, cyc + 2);
        @(negedge clk);
        flag = 3'b000;
        repeat (2) @(negedge clk);

        // reset while in WAIT_DONE
        start = 1'b1; op = 1'b0; addr = 32'hFFFF_FFFF;
        ex(48'h51FFFFFFFF01, ACT, 1'b1, 1'b0, 1'b0, cyc + 1);
        @(negedge clk);
        start = 1'b0; flag = 3'b100;
        ex(IDLE_F, ACT, 1'b1, 1'b0, 1'b0, cyc + 1);
        @(negedge clk);
        flag = 3'b000; start = 1'b1;
        @(negedge clk);
        start = 1'b0; rst = 1'b1; flag = 3'b110;
        ex(IDLE_F, 9'd0, 1'b0, 1'b0, 1'b0, cyc + 1);
        @(negedge clk);
        rst = 1'b0; flag = 3'b000;
        repeat (2) @(negedge clk);

        // no flags after start
        start = 1'b1; op = 1'b1; addr = 32'h0; wdata = 32'h0;
        t0 = cyc + 1;
        ex(48'h580000000001, ACT, 1'b1, 1'b0, 1'b0, t0);
        @(negedge clk);
        start = 1'b0;
`ifdef SD_SEQ_TIMEOUT_EN
        ex(IDLE_F, 9'd0, 1'b1, 1'b0, 1'b1, t0 + 8);
        ex(IDLE_F, 9'd0, 1'b0, 1'b0, 1'b0, t0 + 9);
        repeat (12) @(negedge clk);
`else
        repeat (1000) @(negedge clk);
        checks++;
        if (spi_data !== 48'h580000000001 || busy !== 1'b1 ||
            spi_status !== ACT) begin
            failures++;
            $display("FAIL hold_in_cmd got data=%h busy=%b st=%b want data=580000000001 busy=1 st=%b",
                     spi_data, busy, spi_status, ACT);
        end
        rst = 1'b1;
        ex(IDLE_F, 9'd0, 1'b0, 1'b0, 1'b0, cyc + 1);
        @(negedge clk);
        rst = 1'b0;
`endif
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain got pending=%0d want pending=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sd_block_sequencer.md
SD_BLOCK_SEQUENCER -- requirements
Module: sd_block_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16'hFFFF: cycles allowed per waiting state before error.
REQ-002 Parameter STATUS_ACTIVE, default 9'b110100111: SPI status word driven while a transfer is active.
REQ-003 master_clk_i  in  1  single clock; all logic on rising edge.
REQ-004 master_rst_i  in  1  synchronous, active-high reset.
REQ-005 seq_start_i  in  1  request a single-block transfer; sampled in IDLE only.
REQ-006 seq_op_i  in  1  0 = block read (CMD17), 1 = block write (CMD24); latched with start.
REQ-007 seq_block_addr_i  in  32  SD block address; latched with start.
REQ-008 seq_wdata_i  in  32  write payload word; latched with start.
REQ-009 spi_flagreg_i  in  3  SPI engine progress flag: 100 cmd accepted, 101 data phase done, 110 transfer complete, 111 card error; others = no event.
REQ-010 spi_data_o  out  48  frame presented to SPI engine.
REQ-011 spi_statusreg_o  out  9  SPI engine control/status word.
REQ-012 seq_busy_o  out  1  high from accepted start until return to IDLE.
REQ-013 seq_done_o  out  1  one-cycle pulse on successful completion.
REQ-014 seq_error_o  out  1  one-cycle pulse on card error or timeout.

Function
REQ-015 States SHALL be IDLE, CMD, DATA, WAIT_DONE, DONE, ERROR; registered Moore outputs.
REQ-016 IDLE: spi_data_o = 48'hFFFFFFFFFFFF, spi_statusreg_o = 9'b0, seq_busy_o = 0.
REQ-017 IDLE with seq_start_i=1 -> CMD next cycle; op, address, wdata latched that edge.
REQ-018 CMD: spi_data_o = {2'b01, cmd[5:0], addr[31:0], 8'h01}; cmd = 6'd17 read, 6'd24 write (write addr 0x00002A00 -> 48'h5800002A0001).
REQ-019 CMD, DATA, WAIT_DONE: spi_statusreg_o = STATUS_ACTIVE, seq_busy_o = 1.
REQ-020 CMD on flag 100 -> DATA if write, WAIT_DONE if read.
REQ-021 DATA: spi_data_o = {8'hFE, wdata[31:0], 8'h00}; on flag 101 -> WAIT_DONE.
REQ-022 WAIT_DONE: spi_data_o = 48'hFFFFFFFFFFFF; on flag 110 -> DONE.
REQ-023 Flags not matching the current state's expected code (except 111) SHALL be ignored.
REQ-024 Flag 111 in CMD, DATA or WAIT_DONE -> ERROR, taking priority over any transition.
REQ-025 DONE: seq_done_o = 1 for exactly one cycle, busy still 1, status 9'b0; -> IDLE.
REQ-026 ERROR: seq_error_o = 1 for exactly one cycle, busy still 1, status 9'b0; -> IDLE.
REQ-027 seq_start_i while not IDLE SHALL be ignored; no queuing.
REQ-028 Start asserted in the IDLE cycle following DONE/ERROR SHALL be accepted (back-to-back allowed).
REQ-029 Latency: start to first CMD frame = 1 cycle; expected flag to next state = 1 cycle.

Reset
REQ-030 master_rst_i=1 SHALL force IDLE and IDLE output values at the next edge, including mid-transfer; done/error not pulsed.
REQ-031 Latched op/address/wdata and timeout counter SHALL clear to 0 on reset.

Configuration
REQ-032 Macro SD_SEQ_TIMEOUT_EN defined: 16-bit counter clears on every state entry, increments each cycle in CMD, DATA, WAIT_DONE; reaching TIMEOUT_CYCLES -> ERROR.
REQ-033 Macro undefined: no counter; waiting states hold indefinitely until expected flag or 111.

Structure
REQ-034 Shared package sd_seq_pkg SHALL hold state encoding, flag codes (100/101/110/111), CMD17/CMD24 indices, idle frame 48'hFFFFFFFFFFFF, token 8'hFE.
REQ-035 Single module; frame formatting as a function in sd_seq_pkg; no sub-module.

Verification
REQ-036 Write, addr 0x00002A00, wdata 0x86232200; flags 100,101,110 -> frames 5800002A0001, FE8623220000, FFFFFFFFFFFF; one done pulse.
REQ-037 Read, addr 0x00000010; flags 100 then 110 -> frame 510000001001, DATA skipped, done pulse, busy falls after DONE.
REQ-038 Write; flag 111 while in DATA -> error pulse, no done, IDLE outputs next cycle.
REQ-039 Reset asserted during WAIT_DONE -> IDLE values next edge, no done/error pulse; start while busy ignored.
REQ-040 SD_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=8, no flags after start -> error pulse 8 cycles after CMD entry; without macro, still in CMD after 1000 cycles.
